ft_tx_framer: RTL

Downstream consumer of the CCD sampling stage. Accepts 12-bit pixel samples and end-of-frame pulses on the main PLL clock and buffers them in a small FIFO. Serialises each entry into two bytes and writes them to the FT245-style USB FIFO bridge with proper TXE# flow control. Replaces free-running write strobes, so host back-pressure can no longer corrupt a frame.

---
 rtl/ft_tx_pkg.sv | 31 +++
 rtl/ft_tx_framer_if.sv | 31 +++
 rtl/ft_tx_fifo.sv | 53 +++++
 rtl/ft_tx_framer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ft_tx_pkg.sv
// Shared types and constants for the FT245-style transmit framer.
package ft_tx_pkg;

  localparam logic [7:0] MARKER_HI = 8'hF5;
  localparam logic [7:0] MARKER_LO = 8'hAA;
  localparam logic [7:0] ESC_FROM  = 8'hAA;
  localparam logic [7:0] ESC_TO    = 8'hAB;

  // One FIFO entry: a 12-bit pixel or an end-of-frame marker.
  typedef struct packed {
    logic        is_marker;
    logic [11:0] data;
  } entry_t;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWait,
    StSetup,
    StPulse,
    StHold
  } state_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ft_tx_framer_if.sv
// Pixel input and FT245 bridge bus grouped for the transmit framer.
// master: the framer; slave: the pixel source / bridge side.
interface ft_tx_framer_if;
  logic        pixel_valid;
  logic [11:0] pixel_data;
  logic        frame_done;
  logic        ft_txe_n;
  logic [7:0]  ft_d_out;
  logic        ft_d_oe;
  logic        ft_wr;

  modport master (
    input  pixel_valid,
    input  pixel_data,
    input  frame_done,
    input  ft_txe_n,
    output ft_d_out,
    output ft_d_oe,
    output ft_wr
  );

  modport slave (
    output pixel_valid,
    output pixel_data,
    output frame_done,
    output ft_txe_n,
    input  ft_d_out,
    input  ft_d_oe,
    input  ft_wr
  );
endinterface

// File: rtl/ft_tx_fifo.sv
// Synchronous first-word-fall-through FIFO of framer entries.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module ft_tx_fifo
  import ft_tx_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  output entry_t                 pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (!do_push && do_pop) count_q <= count_q - 1'b1;
    end
  end

  // Storage array, no reset needed: occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem[rd_ptr_q];
  assign level    = count_q;

endmodule

// File: rtl/ft_tx_framer.sv
// Buffers pixel samples and end-of-frame markers, then writes each entry as
// two bytes to an FT245-style bridge under TXE# flow control.
// Optional build macro FT_TX_ESCAPE_EN: a pixel low byte of 8'hAA is sent
// as 8'hAB so that 8'hAA on the wire only ever follows a marker's 8'hF5.
module ft_tx_framer
  import ft_tx_pkg::*;
#(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned WR_SETUP = 2,
  parameter int unsigned WR_PULSE = 4,
  parameter int unsigned WR_HOLD  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  ft_tx_framer_if.master         bus,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int unsigned CNT_MAX = max3(WR_SETUP, WR_PULSE, WR_HOLD);
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            byte_idx_q, byte_idx_d;
  logic [7:0]      byte0_q, byte1_q;
  logic [7:0]      enc0, enc1, cur_byte;
  logic            txe_s1_q, txe_s2_q;
  logic            marker_pend_q;
  logic            overflow_q;
  logic            push, pop, push_ok;
  logic            fifo_full, fifo_empty;
  entry_t          push_entry, head;

  ft_tx_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Push arbitration: a pixel always wins; a pending marker fills idle slots.
  always_comb begin
    push       = 1'b0;
    push_entry = '0;
    if (bus.pixel_valid) begin
      push            = 1'b1;
      push_entry.data = bus.pixel_data;
    end else if (marker_pend_q) begin
      push                 = 1'b1;
      push_entry.is_marker = 1'b1;
    end
  end

  assign pop     = (state_q == StLoad);
  assign push_ok = !fifo_full || pop;

  // Marker bookkeeping and sticky overflow; a blocked marker is retried.
  always_ff @(posedge clk) begin
    if (rst) begin
      marker_pend_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      if (bus.frame_done)                   marker_pend_q <= 1'b1;
      else if (!bus.pixel_valid && push_ok) marker_pend_q <= 1'b0;
      if (bus.pixel_valid && !push_ok)      overflow_q    <= 1'b1;
    end
  end

  assign overflow = overflow_q;

  // Two-byte encoding of the FIFO head.
  always_comb begin
    if (head.is_marker) begin
      enc0 = MARKER_HI;
      enc1 = MARKER_LO;
    end else begin
      enc0 = {4'b0000, head.data[11:8]};
      enc1 = head.data[7:0];
`ifdef FT_TX_ESCAPE_EN
      if (enc1 == ESC_FROM) enc1 = ESC_TO;
`endif
    end
  end

  // TXE# synchroniser and byte latches; TXE# resets to "not ready".
  always_ff @(posedge clk) begin
    if (rst) begin
      txe_s1_q <= 1'b1;
      txe_s2_q <= 1'b1;
      byte0_q  <= '0;
      byte1_q  <= '0;
    end else begin
      txe_s1_q <= bus.ft_txe_n;
      txe_s2_q <= txe_s1_q;
      if (state_q == StLoad) begin
        byte0_q <= enc0;
        byte1_q <= enc1;
      end
    end
  end

  // FSM state register with phase counter and byte index.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      byte_idx_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      byte_idx_q <= byte_idx_d;
    end
  end

  // FSM next state; TXE# is only consulted in StWait so a byte in flight completes.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    byte_idx_d = byte_idx_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!fifo_empty) state_d = StLoad;
      end
      StLoad: begin
        cnt_d      = '0;
        byte_idx_d = 1'b0;
        state_d    = StWait;
      end
      StWait: begin
        cnt_d = '0;
        if (!txe_s2_q) state_d = StSetup;
      end
      StSetup: begin
        if (cnt_q == CW'(WR_SETUP - 1)) begin
          cnt_d   = '0;
          state_d = StPulse;
        end
      end
      StPulse: begin
        if (cnt_q == CW'(WR_PULSE - 1)) begin
          cnt_d   = '0;
          state_d = StHold;
        end
      end
      StHold: begin
        if (cnt_q == CW'(WR_HOLD - 1)) begin
          cnt_d = '0;
          if (!byte_idx_q) begin
            byte_idx_d = 1'b1;
            state_d    = StWait;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  assign cur_byte = byte_idx_q ? byte1_q : byte0_q;

  // FSM outputs: data driven through setup, pulse and hold; strobe in pulse only.
  always_comb begin
    bus.ft_d_out = '0;
    bus.ft_d_oe  = 1'b0;
    bus.ft_wr    = 1'b0;
    unique case (state_q)
      StSetup, StHold: begin
        bus.ft_d_out = cur_byte;
        bus.ft_d_oe  = 1'b1;
      end
      StPulse: begin
        bus.ft_d_out = cur_byte;
        bus.ft_d_oe  = 1'b1;
        bus.ft_wr    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
